// File: rtl/uart_tx.sv
// uart_tx: UART transmit engine.
//   Accepts bytes on a valid/ready write port into a buffer and serialises
//   each one as start bit, 8 data bits LSB first, optional parity bit and
//   1 or 2 stop bits. Bit timing is derived from a shared 16x baud tick.
//   Parity bit = ^data ^ parity_odd, matching the receive block.
//
// Configuration macro:
//   UART_TX_FIFO_EN  defined   -> 4-entry FIFO, tx_level 0..4
//                    undefined -> single holding register, tx_level 0..1
//
// Ports:
//   clk_i          in   clock
//   rst_i          in   asynchronous active-high reset
//   tx_enable      in   block enable; low aborts the frame and idles the line
//   tick_baud_x16  in   single-cycle strobe at 16x baud
//   parity_enable  in   append a parity bit
//   parity_odd     in   1 = odd parity, 0 = even
//   two_stop       in   1 = two stop bits
//   wr_valid       in   write request
//   wr_data[7:0]   in   byte to send
//   wr_ready       out  buffer not full
//   tx_level[2:0]  out  bytes buffered, excluding the frame in flight
//   tick_baud      out  registered 1x baud strobe
//   idle           out  no frame in flight
//   tx             out  serial line
module uart_tx (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tx_enable,
    input  logic       tick_baud_x16,
    input  logic       parity_enable,
    input  logic       parity_odd,
    input  logic       two_stop,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic [2:0] tx_level,
    output logic       tick_baud,
    output logic       idle,
    output logic       tx
);

`ifdef UART_TX_FIFO_EN
    localparam int unsigned DEPTH = 4;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned LVL_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SREG_W = 11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    div_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [SREG_W-1:0]   sreg;
    logic [7:0]          head;
    logic                push;
    logic                pop;
    logic                frame_end;
    logic                buf_empty;
    logic [LVL_W-1:0]    level_nxt;

    assign buf_empty = (tx_level == '0);
    assign push      = wr_valid & wr_ready;
    assign frame_end = (state == ST_SHIFT) && (bit_cnt == CNT_W'(1));
    // A byte leaves the buffer only on a baud tick when the line is free,
    // which includes the last tick of the current frame (no gap bit).
    assign pop       = tx_enable && tick_baud && !buf_empty &&
                       ((state == ST_IDLE) || frame_end);

    // Next occupancy; simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_nxt = tx_level;
        unique case ({push, pop})
            2'b10:   level_nxt = LVL_W'(tx_level + LVL_W'(1));
            2'b01:   level_nxt = LVL_W'(tx_level - LVL_W'(1));
            default: level_nxt = tx_level;
        endcase
    end

    // Occupancy and registered ready flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_level <= '0;
            wr_ready <= 1'b1;
        end else begin
            tx_level <= level_nxt;
            wr_ready <= (level_nxt != LVL_W'(DEPTH));
        end
    end

`ifdef UART_TX_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;

    assign head = fifo_mem[rd_ptr];

    // Circular buffer storage and pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= wr_data;
                wr_ptr           <= 2'(wr_ptr + 2'd1);
            end
            if (pop) begin
                rd_ptr <= 2'(rd_ptr + 2'd1);
            end
        end
    end
`else
    logic [7:0] hold_q;

    assign head = hold_q;

    // Single holding register; occupancy lives in tx_level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q <= '0;
        end else if (push) begin
            hold_q <= wr_data;
        end
    end
`endif

    // Baud divider: one tick_baud per 16 tick_baud_x16, held at 0 while disabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt   <= '0;
            tick_baud <= 1'b0;
        end else if (!tx_enable) begin
            div_cnt   <= '0;
            tick_baud <= 1'b0;
        end else begin
            tick_baud <= tick_baud_x16 && (div_cnt == CNT_W'(15));
            if (tick_baud_x16) begin
                div_cnt <= CNT_W'(div_cnt + CNT_W'(1));
            end
        end
    end

    // Frame FSM. sreg holds {stop, stop/parity, data}; bit_cnt counts the
    // remaining bit times of the frame including the one now on the line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            idle    <= 1'b1;
            sreg    <= '1;
            bit_cnt <= '0;
        end else if (!tx_enable) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            idle    <= 1'b1;
            bit_cnt <= '0;
        end else if (tick_baud) begin
            if (pop) begin
                // Start a frame; line settings are captured here for its duration.
                state   <= ST_SHIFT;
                tx      <= 1'b0;
                idle    <= 1'b0;
                sreg    <= {2'b11, parity_enable ? (^head ^ parity_odd) : 1'b1, head};
                bit_cnt <= CNT_W'(10) + CNT_W'(parity_enable) + CNT_W'(two_stop);
            end else if (frame_end) begin
                state   <= ST_IDLE;
                tx      <= 1'b1;
                idle    <= 1'b1;
                bit_cnt <= '0;
            end else if (state == ST_SHIFT) begin
                tx      <= sreg[0];
                sreg    <= {1'b1, sreg[SREG_W-1:1]};
                bit_cnt <= CNT_W'(bit_cnt - CNT_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx.
//   Frames are checked bit by bit on both the first and last cycle of every
//   bit time, so each bit must hold for exactly 16 cycles when the x16 tick
//   runs every cycle. Works for both buffer configurations (UART_TX_FIFO_EN).
module tb_uart_tx;

`ifdef UART_TX_FIFO_EN
    localparam int unsigned DEPTH = 4;
`else
    localparam int unsigned DEPTH = 1;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       tx_enable;
    logic       tick_baud_x16;
    logic       parity_enable;
    logic       parity_odd;
    logic       two_stop;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [2:0] tx_level;
    logic       tick_baud;
    logic       idle;
    logic       tx;

    int checks   = 0;
    int failures = 0;

    // Expected frames for 0xA1..0xA5, no parity, 1 stop: {stop, data, start}
    // in bits [9:0], unused upper bits read as 1.
    logic [11:0] exp_a [5] = '{12'hF42, 12'hF44, 12'hF46, 12'hF48, 12'hF4A};

    uart_tx dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .tx_enable     (tx_enable),
        .tick_baud_x16 (tick_baud_x16),
        .parity_enable (parity_enable),
        .parity_odd    (parity_odd),
        .two_stop      (two_stop),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .tx_level      (tx_level),
        .tick_baud     (tick_baud),
        .idle          (idle),
        .tx            (tx)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte for one clock edge; caller ensures wr_ready is high.
    task automatic write_byte(input logic [7:0] d);
        @(negedge clk_i);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk_i);
        wr_valid = 1'b0;
    endtask

    // Advance to the first negedge showing the start bit (bounded).
    task automatic wait_start(input string tag);
        int w = 0;
        while (tx !== 1'b0 && w < 400) begin
            @(negedge clk_i);
            w++;
        end
        check({tag, "_start"}, 12'(tx), 12'd0);
    endtask

    // Check a whole frame of n bits; ends at the negedge just after it.
    task automatic expect_frame(input string tag, input logic [11:0] expv,
                                input int n, input logic end_idle);
        logic [11:0] first_v = 12'hFFF;
        logic [11:0] last_v  = 12'hFFF;
        logic        idle_last = 1'b1;
        wait_start(tag);
        check({tag, "_idle_lo"}, 12'(idle), 12'd0);
        for (int c = 0; c < 16 * n; c++) begin
            if (c % 16 == 0)  first_v[c / 16] = tx;
            if (c % 16 == 15) last_v[c / 16]  = tx;
            if (c == 16 * n - 1) idle_last = idle;
            @(negedge clk_i);
        end
        check({tag, "_bits_first"}, first_v, expv);
        check({tag, "_bits_last"},  last_v,  expv);
        check({tag, "_idle_before_end"}, 12'(idle_last), 12'd0);
        if (end_idle) begin
            check({tag, "_end_tx"},   12'(tx),   12'd1);
            check({tag, "_end_idle"}, 12'(idle), 12'd1);
        end else begin
            check({tag, "_next_start_tx"},   12'(tx),   12'd0);
            check({tag, "_next_start_idle"}, 12'(idle), 12'd0);
        end
    endtask

    initial begin
        int cnt;
        rst_i         = 1'b1;
        tx_enable     = 1'b1;
        tick_baud_x16 = 1'b1;
        parity_enable = 1'b0;
        parity_odd    = 1'b0;
        two_stop      = 1'b0;
        wr_valid      = 1'b0;
        wr_data       = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk_i);
        check("rst_tx",        12'(tx),        12'd1);
        check("rst_idle",      12'(idle),      12'd1);
        check("rst_wr_ready",  12'(wr_ready),  12'd1);
        check("rst_tx_level",  12'(tx_level),  12'd0);
        check("rst_tick_baud", 12'(tick_baud), 12'd0);
        rst_i = 1'b0;

        // Divider: x16 every cycle -> 10 pulses in 160 cycles.
        cnt = 0;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk_i);
            if (tick_baud === 1'b1) cnt++;
        end
        check("div_every_cycle", 12'(cnt), 12'd10);

        // x16 every other cycle -> 5 pulses in 160 cycles.
        cnt = 0;
        for (int c = 0; c < 160; c++) begin
            tick_baud_x16 = c[0];
            @(negedge clk_i);
            if (tick_baud === 1'b1) cnt++;
        end
        check("div_half_rate", 12'(cnt), 12'd5);

        // Disabled: no baud ticks.
        tick_baud_x16 = 1'b1;
        tx_enable     = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (tick_baud === 1'b1) cnt++;
        end
        check("div_disabled", 12'(cnt), 12'd0);
        tx_enable = 1'b1;

        // 0x55, no parity, 1 stop: 0,1,0,1,0,1,0,1,0,1.
        write_byte(8'h55);
        expect_frame("f55", 12'hEAA, 10, 1'b1);

        // 0x07 with even parity -> parity bit 1.
        parity_enable = 1'b1;
        parity_odd    = 1'b0;
        write_byte(8'h07);
        expect_frame("f07_even", 12'hE0E, 11, 1'b1);

        // 0x07 with odd parity -> parity bit 0.
        parity_odd = 1'b1;
        write_byte(8'h07);
        expect_frame("f07_odd", 12'hC0E, 11, 1'b1);

        // 0x00, two stop, no parity: 11 bit times.
        parity_enable = 1'b0;
        parity_odd    = 1'b0;
        two_stop      = 1'b1;
        write_byte(8'h00);
        expect_frame("f00_2stop", 12'hE00, 11, 1'b1);

        // 0x00, two stop, even parity (bit 0): 12 bit times.
        parity_enable = 1'b1;
        write_byte(8'h00);
        expect_frame("f00_2stop_par", 12'hC00, 12, 1'b1);
        parity_enable = 1'b0;
        two_stop      = 1'b0;

        // Fill the buffer while disabled, keep wr_valid held, then enable.
        tx_enable = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk_i);
            check("fill_ready", 12'(wr_ready), 12'd1);
            wr_valid = 1'b1;
            wr_data  = 8'(8'hA1 + 8'(i));
        end
        @(negedge clk_i);
        wr_data = 8'(8'hA1 + 8'(DEPTH));
        check("full_ready", 12'(wr_ready), 12'd0);
        check("full_level", 12'(tx_level), 12'(DEPTH));
        tx_enable = 1'b1;
        cnt = 0;
        while (wr_ready !== 1'b1 && cnt < 40) begin
            @(negedge clk_i);
            cnt++;
        end
        check("pop_frees_slot", 12'(wr_ready), 12'd1);
        fork
            expect_frame("fifo_f0", exp_a[0], 10, 1'b0);
            begin
                @(negedge clk_i);
                wr_valid = 1'b0;
                check("refill_level", 12'(tx_level), 12'(DEPTH));
                check("refill_ready", 12'(wr_ready), 12'd0);
            end
        join
        for (int i = 1; i <= int'(DEPTH); i++) begin
            expect_frame("fifo_fn", exp_a[i], 10, (i == int'(DEPTH)));
        end
        check("drain_level", 12'(tx_level), 12'd0);

        // Drop tx_enable during a zero data bit; buffered byte survives.
        write_byte(8'h00);
        wait_start("abort");
        write_byte(8'hC3);
        repeat (52) @(negedge clk_i);
        check("abort_pre_tx", 12'(tx), 12'd0);
        tx_enable = 1'b0;
        @(negedge clk_i);
        check("abort_tx",    12'(tx),       12'd1);
        check("abort_idle",  12'(idle),     12'd1);
        check("abort_level", 12'(tx_level), 12'd1);
        check("abort_ready", 12'(wr_ready), 12'(DEPTH != 1));
        repeat (20) @(negedge clk_i);
        check("abort_hold_tx", 12'(tx), 12'd1);
        tx_enable = 1'b1;
        expect_frame("fC3", 12'hF86, 10, 1'b1);

        // Asynchronous reset mid-frame clears everything at once.
        write_byte(8'h00);
        wait_start("rst_mid");
        write_byte(8'h5A);
        repeat (38) @(negedge clk_i);
        check("rstm_pre_tx",    12'(tx),       12'd0);
        check("rstm_pre_level", 12'(tx_level), 12'd1);
        #1 rst_i = 1'b1;
        #1;
        check("rstm_tx",       12'(tx),       12'd1);
        check("rstm_idle",     12'(idle),     12'd1);
        check("rstm_level",    12'(tx_level), 12'd0);
        check("rstm_wr_ready", 12'(wr_ready), 12'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_i);
            if (tx !== 1'b1) cnt++;
        end
        check("rstm_buffer_lost", 12'(cnt), 12'd0);
        check("rstm_idle_after",  12'(idle), 12'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmit engine paired with the UART receive block. It accepts bytes over a valid/ready write port and buffers them. It serialises each byte onto `tx` as a frame: start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits. Bit timing comes from the shared 16x baud tick, and it uses the same parity convention as the receiver, so a loopback of `tx` to the receive path produces no frame or parity errors.

## Interface
- No parameters; buffer depth is set by the configuration macro.
- `clk_i` in 1: sole clock.
- `rst_i` in 1: reset, asynchronous and active-high.
- `tx_enable` in 1: block enable; low means abort and hold the line idle.
- `tick_baud_x16` in 1: single-cycle strobe at 16x the baud rate.
- `parity_enable` in 1: append a parity bit.
- `parity_odd` in 1: 1 selects odd parity, 0 selects even.
- `two_stop` in 1: 1 selects two stop bits.
- `wr_valid` in 1: write request.
- `wr_data` in 8: byte to send.
- `wr_ready` out 1: buffer not full.
- `tx_level` out 3: number of bytes buffered, excluding the frame in flight.
- `tick_baud` out 1: registered 1x baud strobe.
- `idle` out 1: no frame in flight.
- `tx` out 1: serial line, registered.

## Operation
- Reset values:
  - `tx`=1, `idle`=1, `wr_ready`=1, `tx_level`=0, `tick_baud`=0.
  - Divider, bit counter and buffer are cleared.
- Baud divider:
  - 4-bit counter increments on each `tick_baud_x16`.
  - When it wraps 15→0, `tick_baud` is registered high for exactly one cycle.
  - The counter is free-running while `tx_enable`=1 and is forced to 0 while `tx_enable`=0.
- Write port:
  - A byte is accepted on a clock edge where `wr_valid & wr_ready`.
  - `wr_ready` = !full; there is no same-cycle bypass when full.
- States: IDLE and SHIFT.
- IDLE → SHIFT: on `tick_baud` when the buffer is non-empty.
  - Pop the head byte.
  - Sample `parity_enable`, `parity_odd` and `two_stop`.
  - Load the shift register with {stop bits, parity, data}.
  - Set the bit counter to N = 10 + `parity_enable` + `two_stop` (range 10..12).
  - Drive `tx`=0 (start bit).
  - Deassert `idle`.
- SHIFT, on each `tick_baud`:
  - `tx` ← sreg[0].
  - Shift right, filling with 1.
  - Decrement the counter.
  - When the counter was 1, go to IDLE: `tx`=1, `idle`=1.
  - If the buffer is non-empty on that same tick, the next frame's start bit is driven immediately. Back-to-back frames have no extra idle bit.
- Parity bit = ^data ^ `parity_odd`.
- Configuration changes mid-frame have no effect on the current frame.
- `tx_enable` falls:
  - The next cycle gives `tx`=1, `idle`=1 and state IDLE.
  - The in-flight frame is discarded.
  - Buffered bytes are retained; writes are still accepted if not full.
- `rst_i` asserted mid-frame: all state returns to reset values asynchronously, and buffered bytes are lost.
- Push and pop in the same cycle: `tx_level` is unchanged and data ordering is preserved.

## Timing
- `tx` changes only on the cycle after `tick_baud`. Each bit lasts exactly 16 `tick_baud_x16` pulses.
- Write-to-start-bit latency when idle and empty: 1 to 16 baud-x16 periods plus 1 cycle, set by divider phase. The divider is not resynchronised on write.
- `wr_ready` and `tx_level` update on the cycle after the push or pop.

## Configuration
- `UART_TX_FIFO_EN` defined:
  - 4-entry FIFO.
  - `tx_level` ranges 0..4.
  - `wr_ready`=0 only at level 4.
- Not defined:
  - Single holding register.
  - `tx_level` ranges 0..1.
  - `wr_ready`=0 whenever the holding register is occupied.
  - All other behaviour is identical.

## Test plan
- `tick_baud_x16` every cycle, no parity, 1 stop, write 0x55: `tx` sequence 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles; `idle` returns to 1 after 160 cycles from the start bit.
- Write 0x07 with `parity_enable`=1: with `parity_odd`=0 the parity bit is 1; with `parity_odd`=1 it is 0; the frame is 11 bits.
- `two_stop`=1, write 0x00: nine 0 bits followed by two 1 bits; total 12 bit times with parity, 11 without.
- With `UART_TX_FIFO_EN`:
  - Hold `wr_valid` with bytes 0xA1..0xA5 while idle.
  - The first 4 bytes are accepted (plus a 5th once the first pops).
  - `wr_ready`=0 while `tx_level`=4.
  - Frames go out back-to-back in order with no gap bit.
- Drop `tx_enable` mid-data-bit: `tx`=1 and `idle`=1 the next cycle; the remaining buffered byte is sent intact after re-enable.
- Assert `rst_i` mid-frame: `tx`=1, `idle`=1, `tx_level`=0 and `wr_ready`=1 immediately, without waiting for a clock edge.
